// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_pkg : shared types for the EX/MEM and MEM/WB pipeline registers      |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
package pipe_pkg;

  // Forwarding-select encodings consumed by the EX-stage operand muxes.
  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  // Control fields only; XLEN-wide data travels alongside because XLEN is per-instance.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [4:0] rd;
  } mem_wb_ctrl_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  function automatic logic is_mem_op(input ex_mem_ctrl_t c);
    return c.valid & (c.mem_read | c.mem_write);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_reg : generic pipeline register with enable and synchronous clear    |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_mem_wb_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_mem_wb_pipe : EX/MEM and MEM/WB registers, data-memory handshake,      |
// |                  writeback port and forwarding sources                    |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module ex_mem_wb_pipe #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ex_valid,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_read,
  input  logic                   ex_mem_write,
  input  logic                   ex_mem_to_reg,
  input  logic [4:0]             ex_rd,
  input  logic [XLEN-1:0]        ex_alu_result,
  input  logic [XLEN-1:0]        ex_rs2_data,
  input  logic                   flush_ex,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [XLEN-1:0]        dmem_addr,
  output logic [XLEN-1:0]        dmem_wdata,
  input  logic                   dmem_ready,
  input  logic [XLEN-1:0]        dmem_rdata,
  output logic                   mem_stall,
  output logic [4:0]             EX_MEM_rd,
  output logic [4:0]             MEM_WB_rd,
  output logic                   EX_MEM_reg_write,
  output logic                   MEM_WB_reg_write,
  output logic [XLEN-1:0]        ex_mem_fwd_data,
  output logic [XLEN-1:0]        mem_wb_fwd_data,
  output logic                   wb_en,
  output logic [4:0]             wb_rd,
  output logic [XLEN-1:0]        wb_data,
  output logic [STALL_CNT_W-1:0] stall_cycles
);
  import pipe_pkg::*;

  localparam int EM_W = $bits(ex_mem_ctrl_t) + 2 * XLEN;
  localparam int MW_W = $bits(mem_wb_ctrl_t) + XLEN;
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  ex_mem_ctrl_t     em_ctrl_d, em_ctrl;
  logic [XLEN-1:0]  em_alu, em_rs2;
  logic [EM_W-1:0]  em_d, em_q;
  logic             em_bubble;

  mem_wb_ctrl_t     mw_ctrl_d, mw_ctrl;
  logic [XLEN-1:0]  mw_result_d, mw_result;
  logic [MW_W-1:0]  mw_d, mw_q;

  mem_state_t       state, state_next;
  logic             wb_done;
  logic [STALL_CNT_W-1:0] stall_cnt;

  // EX/MEM: a bubble is produced by clearing the whole register, not just the valid bit.
  always_comb begin
    em_ctrl_d            = '0;
    em_ctrl_d.valid      = 1'b1;
    em_ctrl_d.reg_write  = ex_reg_write & (ex_rd != 5'd0);
    em_ctrl_d.mem_read   = ex_mem_read;
    em_ctrl_d.mem_write  = ex_mem_write;
    em_ctrl_d.mem_to_reg = ex_mem_to_reg;
    em_ctrl_d.rd         = ex_rd;
  end

  assign em_bubble = flush_ex | ~ex_valid;
  assign em_d      = {em_ctrl_d, ex_alu_result, ex_rs2_data};

  pipe_reg #(.WIDTH(EM_W)) u_ex_mem (
    .clk   (clk),
    .reset (reset),
    .en    (~mem_stall),
    .clr   (em_bubble & ~mem_stall),
    .d     (em_d),
    .q     (em_q)
  );

  assign {em_ctrl, em_alu, em_rs2} = em_q;

  // Memory handshake
  assign dmem_req   = is_mem_op(em_ctrl);
  assign dmem_we    = em_ctrl.valid & em_ctrl.mem_write;
  assign dmem_addr  = em_alu;
  assign dmem_wdata = em_rs2;
  assign mem_stall  = dmem_req & ~dmem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dmem_req && !dmem_ready) state_next = WAIT;
      WAIT:    if (dmem_ready)              state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // MEM/WB
  always_comb begin
    mw_ctrl_d           = '0;
    mw_ctrl_d.valid     = em_ctrl.valid;
    mw_ctrl_d.reg_write = em_ctrl.valid & em_ctrl.reg_write;
    mw_ctrl_d.rd        = em_ctrl.rd;
    mw_result_d         = em_ctrl.mem_to_reg ? dmem_rdata : em_alu;
  end

  assign mw_d = {mw_ctrl_d, mw_result_d};

  pipe_reg #(.WIDTH(MW_W)) u_mem_wb (
    .clk   (clk),
    .reset (reset),
    .en    (~mem_stall),
    .clr   (1'b0),
    .d     (mw_d),
    .q     (mw_q)
  );

  assign {mw_ctrl, mw_result} = mw_q;

  // A held entry has already written back in its first cycle; a fresh capture re-arms it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_done <= 1'b0;
    end else begin
      wb_done <= mem_stall;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (mem_stall && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign EX_MEM_rd        = em_ctrl.rd;
  assign EX_MEM_reg_write = em_ctrl.valid & em_ctrl.reg_write;
  assign ex_mem_fwd_data  = em_alu;
  assign MEM_WB_rd        = mw_ctrl.rd;
  assign MEM_WB_reg_write = mw_ctrl.reg_write;
  assign mem_wb_fwd_data  = mw_result;
  assign wb_en            = mw_ctrl.valid & mw_ctrl.reg_write & ~wb_done;
  assign wb_rd            = mw_ctrl.rd;
  assign wb_data          = mw_result;
  assign stall_cycles     = stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_wb_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ex_mem_wb_pipe : directed vector table plus randomized run against a   |
// |                     transaction-level reference model                     |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module tb_ex_mem_wb_pipe;
  localparam int XLEN = 32;
  localparam int SCW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [4:0] ex_rd;
  logic [XLEN-1:0] ex_alu_result, ex_rs2_data, dmem_rdata;
  logic flush_ex, dmem_ready;

  logic dmem_req, dmem_we, mem_stall, EX_MEM_reg_write, MEM_WB_reg_write, wb_en;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, ex_mem_fwd_data, mem_wb_fwd_data, wb_data;
  logic [4:0] EX_MEM_rd, MEM_WB_rd, wb_rd;
  logic [SCW-1:0] stall_cycles;

  ex_mem_wb_pipe #(.XLEN(XLEN), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .flush_ex(flush_ex),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .EX_MEM_rd(EX_MEM_rd), .MEM_WB_rd(MEM_WB_rd),
    .EX_MEM_reg_write(EX_MEM_reg_write), .MEM_WB_reg_write(MEM_WB_reg_write),
    .ex_mem_fwd_data(ex_mem_fwd_data), .mem_wb_fwd_data(mem_wb_fwd_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .stall_cycles(stall_cycles)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one record per in-flight instruction, tagged with an issue number.
  typedef struct {
    bit        valid, rw, mr, mw, m2r;
    bit [4:0]  rd;
    bit [31:0] alu, rs2;
    int        seq;
  } em_m_t;
  typedef struct {
    bit        valid, rw;
    bit [4:0]  rd;
    bit [31:0] data;
    int        seq;
  } mw_m_t;

  em_m_t m_em;
  mw_m_t m_mw;
  int          wrote_seq = -1;
  int          seq_ctr   = 0;
  int unsigned m_cnt     = 0;

  function automatic bit exp_req();
    return m_em.valid && (m_em.mr || m_em.mw);
  endfunction

  function automatic bit exp_wben();
    return m_mw.valid && m_mw.rw && (m_mw.seq != wrote_seq);
  endfunction

  task automatic check_model();
    bit req, stall;
    req   = exp_req();
    stall = req && !dmem_ready;
    chk("mem_stall", mem_stall, stall);
    chk("dmem_req", dmem_req, req);
    chk("dmem_we", dmem_we, req && m_em.mw);
    if (req) begin
      chk("dmem_addr", dmem_addr, m_em.alu);
      chk("dmem_wdata", dmem_wdata, m_em.rs2);
    end
    chk("EX_MEM_reg_write", EX_MEM_reg_write, m_em.valid && m_em.rw);
    if (m_em.valid) begin
      chk("EX_MEM_rd", EX_MEM_rd, m_em.rd);
      chk("ex_mem_fwd_data", ex_mem_fwd_data, m_em.alu);
    end
    chk("MEM_WB_reg_write", MEM_WB_reg_write, m_mw.valid && m_mw.rw);
    if (m_mw.valid) begin
      chk("MEM_WB_rd", MEM_WB_rd, m_mw.rd);
      chk("mem_wb_fwd_data", mem_wb_fwd_data, m_mw.data);
      chk("wb_rd", wb_rd, m_mw.rd);
      chk("wb_data", wb_data, m_mw.data);
    end
    chk("wb_en", wb_en, exp_wben());
    chk("stall_cycles", stall_cycles, m_cnt);
  endtask

  task automatic model_update();
    bit stall;
    if (reset) begin
      m_em = '{default: 0};
      m_mw = '{default: 0};
      m_cnt = 0;
      wrote_seq = -1;
    end else begin
      stall = exp_req() && !dmem_ready;
      if (exp_wben()) wrote_seq = m_mw.seq;
      if (stall) begin
        if (m_cnt < (1 << SCW) - 1) m_cnt++;
      end else begin
        m_mw.valid = m_em.valid;
        m_mw.rw    = m_em.valid && m_em.rw;
        m_mw.rd    = m_em.rd;
        m_mw.data  = m_em.m2r ? dmem_rdata : m_em.alu;
        m_mw.seq   = m_em.seq;
        seq_ctr++;
        m_em.valid = ex_valid && !flush_ex;
        m_em.rw    = m_em.valid && ex_reg_write && (ex_rd != 5'd0);
        m_em.mr    = m_em.valid && ex_mem_read;
        m_em.mw    = m_em.valid && ex_mem_write;
        m_em.m2r   = m_em.valid && ex_mem_to_reg;
        m_em.rd    = ex_rd;
        m_em.alu   = ex_alu_result;
        m_em.rs2   = ex_rs2_data;
        m_em.seq   = seq_ctr;
      end
    end
  endtask

  task automatic drive(input bit rst, input bit v, input bit rw, input bit mr, input bit mwr,
                       input bit m2r, input bit [4:0] rd, input bit [31:0] alu,
                       input bit [31:0] rs2, input bit fl, input bit rdy, input bit [31:0] rdata);
    reset = rst; ex_valid = v; ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mwr;
    ex_mem_to_reg = m2r; ex_rd = rd; ex_alu_result = alu; ex_rs2_data = rs2;
    flush_ex = fl; dmem_ready = rdy; dmem_rdata = rdata;
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_zero();
    chk("zero dmem_req", dmem_req, 0);
    chk("zero dmem_we", dmem_we, 0);
    chk("zero dmem_addr", dmem_addr, 0);
    chk("zero dmem_wdata", dmem_wdata, 0);
    chk("zero mem_stall", mem_stall, 0);
    chk("zero EX_MEM_rd", EX_MEM_rd, 0);
    chk("zero MEM_WB_rd", MEM_WB_rd, 0);
    chk("zero EX_MEM_reg_write", EX_MEM_reg_write, 0);
    chk("zero MEM_WB_reg_write", MEM_WB_reg_write, 0);
    chk("zero ex_mem_fwd_data", ex_mem_fwd_data, 0);
    chk("zero mem_wb_fwd_data", mem_wb_fwd_data, 0);
    chk("zero wb_en", wb_en, 0);
    chk("zero wb_rd", wb_rd, 0);
    chk("zero wb_data", wb_data, 0);
    chk("zero stall_cycles", stall_cycles, 0);
  endtask

  typedef struct {
    bit rst, v, rw, mr, mwr, m2r; bit [4:0] rd; bit [31:0] alu, rs2; bit fl, rdy; bit [31:0] rdata;
    bit e_stall, e_req, e_wben; bit [4:0] e_wbrd; bit [31:0] e_wbdata;
    bit e_emrw; bit [4:0] e_emrd; bit e_mwrw; bit [4:0] e_mwrd; int e_scnt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(
      input bit rst, input bit v, input bit rw, input bit mr, input bit mwr, input bit m2r,
      input bit [4:0] rd, input bit [31:0] alu, input bit [31:0] rs2, input bit fl,
      input bit rdy, input bit [31:0] rdata,
      input bit st, input bit rq, input bit we, input bit [4:0] wrd, input bit [31:0] wd,
      input bit emrw, input bit [4:0] emrd, input bit mwrw, input bit [4:0] mwrd, input int sc);
    vec_t t;
    t.rst = rst; t.v = v; t.rw = rw; t.mr = mr; t.mwr = mwr; t.m2r = m2r; t.rd = rd;
    t.alu = alu; t.rs2 = rs2; t.fl = fl; t.rdy = rdy; t.rdata = rdata;
    t.e_stall = st; t.e_req = rq; t.e_wben = we; t.e_wbrd = wrd; t.e_wbdata = wd;
    t.e_emrw = emrw; t.e_emrd = emrd; t.e_mwrw = mwrw; t.e_mwrd = mwrd; t.e_scnt = sc;
    tbl.push_back(t);
  endfunction

  initial begin
    // Row k: inputs held during cycle k; expectations observed in that cycle.
    //    rst v rw mr mw m2r rd alu     rs2           fl rdy rdata          st rq we wrd wdata        emrw emrd mwrw mwrd scnt
    // zero-wait load
    add(0, 1,1,1,0,1, 5,'h100, 0,          0,1,0,             0,0,0,0,0,            0,0,0,0,0);
    add(0, 0,0,0,0,0, 0,0,     0,          0,1,'hDEADBEEF,    0,1,0,0,0,            1,5,0,0,0);
    add(0, 0,0,0,0,0, 0,0,     0,          0,1,0,             0,0,1,5,'hDEADBEEF,   0,0,1,5,0);
    // three-wait store
    add(0, 1,0,0,1,0, 0,'h200, 'hCAFE0001, 0,0,0,             0,0,0,0,0,            0,0,0,0,0);
    add(0, 0,0,0,0,0, 0,0,     0,          0,0,0,             1,1,0,0,0,            0,0,0,0,0);
    add(0, 0,0,0,0,0, 0,0,     0,          0,0,0,             1,1,0,0,0,            0,0,0,0,1);
    add(0, 0,0,0,0,0, 0,0,     0,          0,0,0,             1,1,0,0,0,            0,0,0,0,2);
    add(0, 0,0,0,0,0, 0,0,     0,          0,1,0,             0,1,0,0,0,            0,0,0,0,3);
    add(0, 0,0,0,0,0, 0,0,     0,          0,1,0,             0,0,0,0,0,            0,0,0,0,3);
    // ALU x7 writes back while the following load waits two cycles
    add(0, 1,1,0,0,0, 7,'h77,  0,          0,1,0,             0,0,0,0,0,            0,0,0,0,3);
    add(0, 1,1,1,0,1, 9,'h300, 0,          0,1,0,             0,0,0,0,0,            1,7,0,0,3);
    add(0, 0,0,0,0,0, 0,0,     0,          0,0,0,             1,1,1,7,'h77,         1,9,1,7,3);
    add(0, 0,0,0,0,0, 0,0,     0,          0,0,0,             1,1,0,0,0,            1,9,1,7,4);
    add(0, 0,0,0,0,0, 0,0,     0,          0,1,'h12345678,    0,1,0,0,0,            1,9,1,7,5);
    add(0, 0,0,0,0,0, 0,0,     0,          0,1,0,             0,0,1,9,'h12345678,   0,0,1,9,5);
    // flush and rd=0 suppression
    add(0, 1,1,0,0,0, 3,'h33,  0,          1,1,0,             0,0,0,0,0,            0,0,0,0,5);
    add(0, 1,1,0,0,0, 0,'h44,  0,          0,1,0,             0,0,0,0,0,            0,0,0,0,5);
    add(0, 0,0,0,0,0, 0,0,     0,          0,1,0,             0,0,0,0,0,            0,0,0,0,5);
    add(0, 0,0,0,0,0, 0,0,     0,          0,1,0,             0,0,0,0,0,            0,0,0,0,5);
    // flush raised while stalled is dropped; taken once the stall ends
    add(0, 1,1,1,0,1, 4,'h400, 0,          0,0,0,             0,0,0,0,0,            0,0,0,0,5);
    add(0, 1,1,0,0,0, 8,'h88,  0,          1,0,0,             1,1,0,0,0,            1,4,0,0,5);
    add(0, 1,1,0,0,0, 8,'h88,  0,          1,1,'hABCD,        0,1,0,0,0,            1,4,0,0,6);
    add(0, 0,0,0,0,0, 0,0,     0,          0,1,0,             0,0,1,4,'hABCD,       0,0,1,4,6);
    // back-to-back ALU ops
    add(0, 1,1,0,0,0, 1,'h1111,0,          0,1,0,             0,0,0,0,0,            0,0,0,0,6);
    add(0, 1,1,0,0,0, 2,'h2222,0,          0,1,0,             0,0,0,0,0,            1,1,0,0,6);
    add(0, 0,0,0,0,0, 0,0,     0,          0,1,0,             0,0,1,1,'h1111,       1,2,1,1,6);
    add(0, 0,0,0,0,0, 0,0,     0,          0,1,0,             0,0,1,2,'h2222,       0,0,1,2,6);
    // reset in the second wait cycle
    add(0, 1,1,1,0,1, 6,'h600, 0,          0,0,0,             0,0,0,0,0,            0,0,0,0,6);
    add(0, 0,0,0,0,0, 0,0,     0,          0,0,0,             1,1,0,0,0,            1,6,0,0,6);
    add(1, 0,0,0,0,0, 0,0,     0,          0,0,0,             1,1,0,0,0,            1,6,0,0,7);
    add(0, 0,0,0,0,0, 0,0,     0,          0,0,0,             0,0,0,0,0,            0,0,0,0,0);

    drive(1, 0,0,0,0,0, 0, 0, 0, 0, 1, 0);
    advance();
    advance();
    drive(0, 0,0,0,0,0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    check_zero();
    check_model();
    advance();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].rw, tbl[i].mr, tbl[i].mwr, tbl[i].m2r, tbl[i].rd,
            tbl[i].alu, tbl[i].rs2, tbl[i].fl, tbl[i].rdy, tbl[i].rdata);
      @(negedge clk);
      check_model();
      if (i > 0 && tbl[i-1].rst) check_zero();
      chk($sformatf("row%0d mem_stall", i), mem_stall, tbl[i].e_stall);
      chk($sformatf("row%0d dmem_req", i), dmem_req, tbl[i].e_req);
      chk($sformatf("row%0d wb_en", i), wb_en, tbl[i].e_wben);
      if (tbl[i].e_wben) begin
        chk($sformatf("row%0d wb_rd", i), wb_rd, tbl[i].e_wbrd);
        chk($sformatf("row%0d wb_data", i), wb_data, tbl[i].e_wbdata);
      end
      chk($sformatf("row%0d EX_MEM_reg_write", i), EX_MEM_reg_write, tbl[i].e_emrw);
      if (tbl[i].e_emrw) chk($sformatf("row%0d EX_MEM_rd", i), EX_MEM_rd, tbl[i].e_emrd);
      chk($sformatf("row%0d MEM_WB_reg_write", i), MEM_WB_reg_write, tbl[i].e_mwrw);
      if (tbl[i].e_mwrw) chk($sformatf("row%0d MEM_WB_rd", i), MEM_WB_rd, tbl[i].e_mwrd);
      chk($sformatf("row%0d stall_cycles", i), stall_cycles, tbl[i].e_scnt);
      advance();
    end

    // Randomized traffic; long stall runs between resets exercise counter saturation.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(199) == 0,
            $urandom_range(7) != 0, $urandom_range(1), $urandom_range(1), $urandom_range(1),
            $urandom_range(1), 5'($urandom_range(31)), $urandom, $urandom,
            $urandom_range(7) == 0, $urandom_range(2) == 0, $urandom);
      @(negedge clk);
      check_model();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
